interrupt_controller: RTL and testbench

INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

---
 rtl/interrupt_controller_if.sv | 35 +++
 rtl/interrupt_controller.sv | 149 ++++++++++++++
 tb/tb_interrupt_controller.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/interrupt_controller_if.sv
// Bus between the interrupt controller and the CPU core: request/mask/boundary
// inputs toward the controller, stack and PC-override controls back to the core.
interface interrupt_controller_if #(
    parameter int WIDTH = 10,
    parameter int NIRQ  = 4
);
    logic [NIRQ-1:0]  irq;
    logic             mask_we;
    logic [NIRQ-1:0]  mask_in;
    logic             instr_done;
    logic             reti;
    logic [WIDTH-1:0] pc_in;

    logic             we_stack;
    logic             s_pushpop;
    logic             s_interruption;
    logic [WIDTH-1:0] stack_data;
    logic             pc_load;
    logic [WIDTH-1:0] pc_vector;
    logic [NIRQ-1:0]  int_ack;
    logic             in_isr;

    // master is the controller itself; slave is the core/environment side
    modport master (
        input  irq, mask_we, mask_in, instr_done, reti, pc_in,
        output we_stack, s_pushpop, s_interruption, stack_data,
               pc_load, pc_vector, int_ack, in_isr
    );

    modport slave (
        output irq, mask_we, mask_in, instr_done, reti, pc_in,
        input  we_stack, s_pushpop, s_interruption, stack_data,
               pc_load, pc_vector, int_ack, in_isr
    );
endinterface

// File: rtl/interrupt_controller.sv
// Non-nesting interrupt controller: IDLE -> PUSH -> VECTOR -> ISR -> POP.
// Define INT_EDGE_DETECT_EN for rising-edge latched requests; default is level-sensitive irq.
module interrupt_controller #(
    parameter int               WIDTH       = 10,
    parameter int               NIRQ        = 4,
    parameter logic [WIDTH-1:0] VECTOR_BASE = 10'h3F0
) (
    input logic                   clk,
    input logic                   reset,
    interrupt_controller_if.master bus
);
    localparam int ID_W = (NIRQ > 1) ? $clog2(NIRQ) : 1;

    typedef enum logic [2:0] {
        IDLE,
        PUSH,
        VECTOR,
        ISR,
        POP
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [NIRQ-1:0]  mask;
    logic [NIRQ-1:0]  pending;
    logic [NIRQ-1:0]  active;
    logic [ID_W-1:0]  id;
    logic [ID_W-1:0]  id_sel;
    logic [WIDTH-1:0] stack_data;
    logic             take;

    logic             we_stack;
    logic             s_pushpop;
    logic             s_interruption;
    logic             pc_load;
    logic [WIDTH-1:0] pc_vector;
    logic [NIRQ-1:0]  int_ack;
    logic             in_isr;

`ifdef INT_EDGE_DETECT_EN
    logic [NIRQ-1:0] irq_prev;
    logic [NIRQ-1:0] clear_mask;

    // A fresh rising edge in the same cycle as the acknowledge keeps the bit set
    assign clear_mask = (state == VECTOR) ? (NIRQ'(1) << id) : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            pending  <= '0;
            irq_prev <= '0;
        end else begin
            pending  <= (pending & ~clear_mask) | (bus.irq & ~irq_prev);
            irq_prev <= bus.irq;
        end
    end
`else
    assign pending = bus.irq;
`endif

    assign active = pending & mask;

    always_comb begin
        id_sel = '0;
        for (int i = NIRQ - 1; i >= 0; i--) begin
            if (active[i]) id_sel = ID_W'(i);
        end
    end

    assign take = (state == IDLE) && bus.instr_done && (|active);

    always_ff @(posedge clk) begin
        if (reset) begin
            mask <= '0;
        end else if (bus.mask_we) begin
            mask <= bus.mask_in;
        end
    end

    // id and return address only change on acceptance, so they survive the whole service
    always_ff @(posedge clk) begin
        if (reset) begin
            id         <= '0;
            stack_data <= '0;
        end else if (take) begin
            id         <= id_sel;
            stack_data <= bus.pc_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (take) state_next = PUSH;
            PUSH:    state_next = VECTOR;
            VECTOR:  state_next = ISR;
            ISR:     if (bus.reti) state_next = POP;
            POP:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        we_stack       = 1'b0;
        s_pushpop      = 1'b0;
        s_interruption = 1'b0;
        pc_load        = 1'b0;
        pc_vector      = '0;
        int_ack        = '0;
        in_isr         = 1'b0;
        unique case (state)
            PUSH: begin
                we_stack       = 1'b1;
                s_interruption = 1'b1;
            end
            VECTOR: begin
                pc_load   = 1'b1;
                pc_vector = VECTOR_BASE + WIDTH'(id);
                int_ack   = NIRQ'(1) << id;
            end
            ISR: begin
                in_isr = 1'b1;
            end
            POP: begin
                we_stack       = 1'b1;
                s_pushpop      = 1'b1;
                s_interruption = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign bus.we_stack       = we_stack;
    assign bus.s_pushpop      = s_pushpop;
    assign bus.s_interruption = s_interruption;
    assign bus.stack_data     = stack_data;
    assign bus.pc_load        = pc_load;
    assign bus.pc_vector      = pc_vector;
    assign bus.int_ack        = int_ack;
    assign bus.in_isr         = in_isr;
endmodule

// File: tb/tb_interrupt_controller.sv
// Self-checking bench for interrupt_controller: directed scenarios plus a
// randomized run compared against a queue-based reference model.
module tb_interrupt_controller;
    localparam int W = 10;
    localparam int N = 4;
    localparam logic [W-1:0] BASE = 10'h3F0;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   fails  = 0;

    interrupt_controller_if #(.WIDTH(W), .NIRQ(N)) bus ();

    interrupt_controller #(
        .WIDTH(W),
        .NIRQ(N),
        .VECTOR_BASE(BASE)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // One record describes every output for one cycle
    typedef struct packed {
        logic         we;
        logic         pp;
        logic         si;
        logic         pcl;
        logic [W-1:0] vec;
        logic [N-1:0] ack;
        logic         isr;
    } rec_t;

    localparam int OW = $bits(rec_t) + W;
    typedef logic [OW-1:0] obs_t;

    rec_t         cur;
    rec_t         q[$];
    logic [N-1:0] m_mask;
    logic [N-1:0] m_pend;
    logic [N-1:0] m_irq_prev;
    logic [W-1:0] m_stack;
    int           m_id;

    function automatic obs_t observed();
        return {bus.we_stack, bus.s_pushpop, bus.s_interruption, bus.pc_load,
                bus.pc_vector, bus.int_ack, bus.in_isr, bus.stack_data};
    endfunction

    function automatic obs_t expected();
        return {cur, m_stack};
    endfunction

    // Reference model: on acceptance, schedule the push and vector cycles, then sit in service until reti
    task automatic model_edge();
        rec_t         nxt;
        rec_t         r;
        logic [N-1:0] cand;
        int           sel;
        if (reset) begin
            q.delete();
            cur        = '0;
            m_mask     = '0;
            m_pend     = '0;
            m_irq_prev = '0;
            m_stack    = '0;
            m_id       = 0;
            return;
        end
        nxt = '0;
`ifdef INT_EDGE_DETECT_EN
        cand = m_pend & m_mask;
`else
        cand = bus.irq & m_mask;
`endif
        if (cur.isr) begin
            if (bus.reti) begin
                nxt.we = 1'b1;
                nxt.pp = 1'b1;
                nxt.si = 1'b1;
            end else begin
                nxt = cur;
            end
        end else if (cur == '0) begin
            sel = -1;
            for (int i = 0; i < N; i++) begin
                if (cand[i]) begin
                    sel = i;
                    break;
                end
            end
            if (bus.instr_done && sel >= 0) begin
                m_id    = sel;
                m_stack = bus.pc_in;
                nxt.we  = 1'b1;
                nxt.si  = 1'b1;
                r       = '0;
                r.pcl   = 1'b1;
                r.vec   = BASE + W'(sel);
                r.ack[sel] = 1'b1;
                q.push_back(r);
                r       = '0;
                r.isr   = 1'b1;
                q.push_back(r);
            end
        end else if (q.size() > 0) begin
            nxt = q.pop_front();
        end
`ifdef INT_EDGE_DETECT_EN
        if (cur.pcl) m_pend[m_id] = 1'b0;
        m_pend     = m_pend | (bus.irq & ~m_irq_prev);
        m_irq_prev = bus.irq;
`endif
        if (bus.mask_we) m_mask = bus.mask_in;
        cur = nxt;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic drive_quiet();
        bus.irq        = '0;
        bus.mask_we    = 1'b0;
        bus.mask_in    = '0;
        bus.instr_done = 1'b0;
        bus.reti       = 1'b0;
        bus.pc_in      = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive_quiet();
        tick();
        tick();
        reset = 1'b0;
        checks++;
        if (observed() !== '0) begin
            fails++;
            $display("[TB] FAIL reset_outputs: got %h, want 0", observed());
        end
        tick();
        checks++;
        if (observed() !== expected()) begin
            fails++;
            $display("[TB] FAIL reset_idle: got %h, want %h", observed(), expected());
        end
    endtask

    task automatic test_basic_vector();
        bus.mask_we = 1'b1;
        bus.mask_in = 4'b0001;
        tick();
        bus.mask_we = 1'b0;
        bus.irq     = 4'b0001;
        tick();
        bus.instr_done = 1'b1;
        bus.pc_in      = 10'h012;
        tick();
        bus.instr_done = 1'b0;
        checks++;
        if (bus.we_stack !== 1'b1 || bus.s_pushpop !== 1'b0 || bus.s_interruption !== 1'b1 ||
            bus.stack_data !== 10'h012 || bus.pc_load !== 1'b0) begin
            fails++;
            $display("[TB] FAIL basic_push: got we=%b pp=%b si=%b data=%h pcl=%b, want 1 0 1 012 0",
                     bus.we_stack, bus.s_pushpop, bus.s_interruption, bus.stack_data, bus.pc_load);
        end
        tick();
        checks++;
        if (bus.pc_load !== 1'b1 || bus.pc_vector !== 10'h3F0 || bus.int_ack !== 4'b0001 ||
            bus.we_stack !== 1'b0) begin
            fails++;
            $display("[TB] FAIL basic_vector: got pcl=%b vec=%h ack=%b we=%b, want 1 3f0 0001 0",
                     bus.pc_load, bus.pc_vector, bus.int_ack, bus.we_stack);
        end
        tick();
        checks++;
        if (bus.in_isr !== 1'b1 || bus.pc_load !== 1'b0 || bus.pc_vector !== '0 || bus.int_ack !== '0) begin
            fails++;
            $display("[TB] FAIL basic_isr: got isr=%b pcl=%b vec=%h ack=%b, want 1 0 000 0000",
                     bus.in_isr, bus.pc_load, bus.pc_vector, bus.int_ack);
        end
        bus.irq  = '0;
        bus.reti = 1'b1;
        tick();
        bus.reti = 1'b0;
        checks++;
        if (bus.we_stack !== 1'b1 || bus.s_pushpop !== 1'b1 || bus.s_interruption !== 1'b1 ||
            bus.in_isr !== 1'b0) begin
            fails++;
            $display("[TB] FAIL basic_pop: got we=%b pp=%b si=%b isr=%b, want 1 1 1 0",
                     bus.we_stack, bus.s_pushpop, bus.s_interruption, bus.in_isr);
        end
        tick();
        checks++;
        if (observed() !== {4'b0000, 10'h000, 4'b0000, 1'b0, 10'h012}) begin
            fails++;
            $display("[TB] FAIL basic_return_idle: got %h, want outputs 0 with stack_data 012", observed());
        end
    endtask

    task automatic test_priority();
        bus.mask_we = 1'b1;
        bus.mask_in = 4'b1111;
        bus.irq     = 4'b1010;
        tick();
        bus.mask_we    = 1'b0;
        bus.instr_done = 1'b1;
        tick();
        bus.instr_done = 1'b0;
        tick();
        checks++;
        if (bus.int_ack !== 4'b0010 || bus.pc_vector !== 10'h3F1 || bus.pc_load !== 1'b1) begin
            fails++;
            $display("[TB] FAIL priority_first: got ack=%b vec=%h pcl=%b, want 0010 3f1 1",
                     bus.int_ack, bus.pc_vector, bus.pc_load);
        end
        bus.irq = 4'b1000;
        tick();
        bus.reti = 1'b1;
        tick();
        bus.reti = 1'b0;
        tick();
        bus.instr_done = 1'b1;
        tick();
        bus.instr_done = 1'b0;
        tick();
        checks++;
        if (bus.int_ack !== 4'b1000 || bus.pc_vector !== 10'h3F3 || bus.pc_load !== 1'b1) begin
            fails++;
            $display("[TB] FAIL priority_second: got ack=%b vec=%h pcl=%b, want 1000 3f3 1",
                     bus.int_ack, bus.pc_vector, bus.pc_load);
        end
        bus.irq = '0;
        tick();
        bus.reti = 1'b1;
        tick();
        bus.reti = 1'b0;
        tick();
    endtask

    task automatic test_mask();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.irq = 4'b0100;
        tick();
        bus.instr_done = 1'b1;
        tick();
        checks++;
        if (bus.we_stack !== 1'b0 || bus.in_isr !== 1'b0) begin
            fails++;
            $display("[TB] FAIL mask_blocks: got we=%b isr=%b, want 0 0", bus.we_stack, bus.in_isr);
        end
        bus.instr_done = 1'b0;
        bus.mask_we    = 1'b1;
        bus.mask_in    = 4'b0100;
        tick();
        bus.mask_we    = 1'b0;
        bus.instr_done = 1'b1;
        tick();
        bus.instr_done = 1'b0;
        checks++;
        if (bus.we_stack !== 1'b1 || bus.s_pushpop !== 1'b0) begin
            fails++;
            $display("[TB] FAIL mask_retained_push: got we=%b pp=%b, want 1 0", bus.we_stack, bus.s_pushpop);
        end
        tick();
        checks++;
        if (bus.int_ack !== 4'b0100 || bus.pc_vector !== 10'h3F2) begin
            fails++;
            $display("[TB] FAIL mask_vector: got ack=%b vec=%h, want 0100 3f2", bus.int_ack, bus.pc_vector);
        end
        bus.irq = '0;
        tick();
        bus.reti = 1'b1;
        tick();
        bus.reti = 1'b0;
        tick();
    endtask

    task automatic test_no_nesting();
        bus.mask_we = 1'b1;
        bus.mask_in = 4'b1111;
        bus.irq     = 4'b0010;
        tick();
        bus.mask_we    = 1'b0;
        bus.instr_done = 1'b1;
        tick();
        bus.instr_done = 1'b0;
        tick();
        tick();
        bus.irq = 4'b0011;
        tick();
        bus.instr_done = 1'b1;
        tick();
        checks++;
        if (bus.we_stack !== 1'b0 || bus.in_isr !== 1'b1) begin
            fails++;
            $display("[TB] FAIL no_nesting: got we=%b isr=%b, want 0 1", bus.we_stack, bus.in_isr);
        end
        bus.irq  = '0;
        bus.reti = 1'b1;
        tick();
        bus.reti       = 1'b0;
        bus.instr_done = 1'b0;
        checks++;
        if (bus.we_stack !== 1'b1 || bus.s_pushpop !== 1'b1 || bus.s_interruption !== 1'b1 ||
            bus.in_isr !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reti_wins_pop: got we=%b pp=%b si=%b isr=%b, want 1 1 1 0",
                     bus.we_stack, bus.s_pushpop, bus.s_interruption, bus.in_isr);
        end
        tick();
        checks++;
        if (bus.we_stack !== 1'b0 || bus.in_isr !== 1'b0 || bus.pc_load !== 1'b0 || bus.s_pushpop !== 1'b0) begin
            fails++;
            $display("[TB] FAIL after_pop_idle: got we=%b isr=%b pcl=%b pp=%b, want 0 0 0 0",
                     bus.we_stack, bus.in_isr, bus.pc_load, bus.s_pushpop);
        end
    endtask

    task automatic test_reset_mid_push();
        bus.irq = 4'b0001;
        tick();
        bus.pc_in      = 10'h155;
        bus.instr_done = 1'b1;
        tick();
        bus.instr_done = 1'b0;
        checks++;
        if (bus.we_stack !== 1'b1) begin
            fails++;
            $display("[TB] FAIL reset_push_entry: got we=%b, want 1", bus.we_stack);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (observed() !== '0) begin
            fails++;
            $display("[TB] FAIL reset_mid_push: got %h, want 0", observed());
        end
        tick();
        checks++;
        if (observed() !== '0) begin
            fails++;
            $display("[TB] FAIL no_partial_stack: got %h, want 0", observed());
        end
        bus.irq = '0;
        tick();
        bus.irq = 4'b0001;
        tick();
        bus.instr_done = 1'b1;
        tick();
        bus.instr_done = 1'b0;
        checks++;
        if (bus.we_stack !== 1'b0) begin
            fails++;
            $display("[TB] FAIL mask_cleared_by_reset: got we=%b, want 0", bus.we_stack);
        end
        bus.irq = '0;
    endtask

    task automatic test_reti_idle();
        bus.reti = 1'b1;
        tick();
        checks++;
        if (observed() !== '0) begin
            fails++;
            $display("[TB] FAIL reti_in_idle: got %h, want 0", observed());
        end
        bus.reti = 1'b0;
        tick();
        checks++;
        if (observed() !== '0) begin
            fails++;
            $display("[TB] FAIL reti_idle_after: got %h, want 0", observed());
        end
    endtask

    task automatic test_random();
        int shown = 0;
        reset = 1'b1;
        drive_quiet();
        tick();
        reset = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            reset          = ($urandom_range(0, 199) == 0);
            bus.irq        = ($urandom_range(0, 3) == 0) ? N'($urandom) : bus.irq;
            bus.mask_we    = ($urandom_range(0, 9) == 0);
            bus.mask_in    = N'($urandom);
            bus.instr_done = ($urandom_range(0, 2) == 0);
            bus.reti       = ($urandom_range(0, 4) == 0);
            bus.pc_in      = W'($urandom);
            tick();
            checks++;
            if (observed() !== expected()) begin
                fails++;
                if (shown < 10) begin
                    shown++;
                    $display("[TB] FAIL random_cycle_%0d: got %h, want %h", c, observed(), expected());
                end
            end
        end
        reset = 1'b0;
        drive_quiet();
    endtask

    initial begin
        cur        = '0;
        m_mask     = '0;
        m_pend     = '0;
        m_irq_prev = '0;
        m_stack    = '0;
        m_id       = 0;
        test_reset();
        test_basic_vector();
        test_priority();
        test_mask();
        test_no_nesting();
        test_reset_mid_push();
        test_reti_idle();
        test_random();
        $display("[TB] %0d tests run, %0d failed", checks, fails);
        $finish;
    end
endmodule
